imm_gen_pipe: RTL and testbench

//  Registered, parametrised successor to the combinational immediate generator.

---
 rtl/imm_gen_pipe.sv | 126 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator (I/S/B/U/J) with a valid/ready handshake.
// A two-entry skid (output reg + skid reg) gives full throughput and a registered InReady.
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter bit AUTO_SRC = 1'b0,
  parameter int TAG_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Inst,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  ImmExt,
  output logic             ImmErr,
  output logic [TAG_W-1:0] OutTag
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [2:0] SRC_I = 3'b000, SRC_S = 3'b001, SRC_U = 3'b010,
                         SRC_B = 3'b101, SRC_J = 3'b110, SRC_BAD = 3'b011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [2:0]  src;
  logic [31:0] imm32;
  ent_t        in_ent;
  ent_t        out_q, out_d, skid_q, skid_d;
  logic        out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic        in_fire, out_fire, out_load;

  // Opcode bits only matter in AUTO_SRC builds.
  logic unused_opcode;
  assign unused_opcode = ^Inst[6:0];

  always_comb begin
    src = ImmSrc;
    if (AUTO_SRC) begin
      case (Inst[6:0])
        7'b0010011, 7'b0000011,
        7'b1100111, 7'b1110011: src = SRC_I;
        7'b0011011:             src = (XLEN == 64) ? SRC_I : SRC_BAD;
        7'b0100011:             src = SRC_S;
        7'b1100011:             src = SRC_B;
        7'b0110111, 7'b0010111: src = SRC_U;
        7'b1101111:             src = SRC_J;
        default:                src = SRC_BAD;
      endcase
    end
  end

  always_comb begin
    imm32      = '0;
    in_ent.err = 1'b0;
    case (src)
      SRC_I:   imm32 = {{20{Inst[31]}}, Inst[31:20]};
      SRC_S:   imm32 = {{20{Inst[31]}}, Inst[31:25], Inst[11:7]};
      SRC_B:   imm32 = {{19{Inst[31]}}, Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0};
      SRC_U:   imm32 = {Inst[31:12], 12'b0};
      SRC_J:   imm32 = {{11{Inst[31]}}, Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0};
      default: in_ent.err = 1'b1;
    endcase
    in_ent.imm = XLEN'($signed(imm32));
    in_ent.tag = InTag;
  end

  assign InReady  = !skid_vld_q && !reset;
  assign in_fire  = InValid && InReady;
  assign out_fire = out_vld_q && OutReady;
  assign out_load = !out_vld_q || out_fire;

  // Skid drains into the output reg first, which keeps ordering FIFO.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (out_load) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        out_d     = in_ent;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign OutValid = out_vld_q;
  assign ImmExt   = out_q.imm;
  assign ImmErr   = out_q.err;
  assign OutTag   = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: three builds (XLEN=32 explicit src, XLEN=64 explicit src, XLEN=32 auto src)
// share the same input stream; each task checks its scenario inline.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic [31:0] Inst;
  logic [2:0]  ImmSrc;
  logic [7:0]  InTag;
  logic        OutReady;

  logic        a_in_rdy, a_vld, a_err;
  logic [31:0] a_imm;
  logic [7:0]  a_tag;
  logic        w_in_rdy, w_vld, w_err;
  logic [63:0] w_imm;
  logic [7:0]  w_tag;
  logic        x_in_rdy, x_vld, x_err;
  logic [31:0] x_imm;
  logic [7:0]  x_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_SRC(1'b0), .TAG_W(8)) u_a (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(a_in_rdy), .Inst(Inst),
    .ImmSrc(ImmSrc), .InTag(InTag), .OutValid(a_vld), .OutReady(OutReady),
    .ImmExt(a_imm), .ImmErr(a_err), .OutTag(a_tag));

  imm_gen_pipe #(.XLEN(64), .AUTO_SRC(1'b0), .TAG_W(8)) u_w (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(w_in_rdy), .Inst(Inst),
    .ImmSrc(ImmSrc), .InTag(InTag), .OutValid(w_vld), .OutReady(OutReady),
    .ImmExt(w_imm), .ImmErr(w_err), .OutTag(w_tag));

  imm_gen_pipe #(.XLEN(32), .AUTO_SRC(1'b1), .TAG_W(8)) u_x (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(x_in_rdy), .Inst(Inst),
    .ImmSrc(ImmSrc), .InTag(InTag), .OutValid(x_vld), .OutReady(OutReady),
    .ImmExt(x_imm), .ImmErr(x_err), .OutTag(x_tag));

  // Present one instruction for one edge, then check all three outputs #1 after acceptance.
  task automatic send_check(input string nm, input logic [31:0] ins, input logic [2:0] src,
                            input logic [31:0] exp_a, input logic exp_aerr,
                            input logic [63:0] exp_w, input logic [31:0] exp_x,
                            input logic exp_xerr);
    Inst = ins; ImmSrc = src; InTag = 8'h5A; InValid = 1'b1; OutReady = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    n_cmp++;
    if ({a_vld, a_err, a_imm} !== {1'b1, exp_aerr, exp_a}) begin
      n_bad++;
      $display("FAIL %s x32: got vld=%b err=%b imm=%h want vld=1 err=%b imm=%h",
               nm, a_vld, a_err, a_imm, exp_aerr, exp_a);
    end
    n_cmp++;
    if ({w_vld, w_err, w_imm} !== {1'b1, exp_aerr, exp_w}) begin
      n_bad++;
      $display("FAIL %s x64: got vld=%b err=%b imm=%h want vld=1 err=%b imm=%h",
               nm, w_vld, w_err, w_imm, exp_aerr, exp_w);
    end
    n_cmp++;
    if ({x_vld, x_err, x_imm, x_tag} !== {1'b1, exp_xerr, exp_x, 8'h5A}) begin
      n_bad++;
      $display("FAIL %s auto: got vld=%b err=%b imm=%h tag=%h want vld=1 err=%b imm=%h tag=5a",
               nm, x_vld, x_err, x_imm, x_tag, exp_xerr, exp_x);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; InValid = 1'b0; Inst = '0; ImmSrc = '0; InTag = '0; OutReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_vld, a_err, a_imm, a_tag, a_in_rdy} !== 42'b0) begin
      n_bad++;
      $display("FAIL reset_state: got vld=%b err=%b imm=%h tag=%h in_rdy=%b want all 0",
               a_vld, a_err, a_imm, a_tag, a_in_rdy);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (a_in_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b want 1", a_in_rdy);
    end
  endtask

  task automatic test_formats();
    send_check("i_type", 32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF,
               32'hFFFFFFFF, 1'b0);
    send_check("s_type", 32'hFE512E23, 3'b001, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC,
               32'hFFFFFFFC, 1'b0);
    send_check("b_type", 32'hFE000CE3, 3'b101, 32'hFFFFFFF8, 1'b0, 64'hFFFFFFFFFFFFFFF8,
               32'hFFFFFFF8, 1'b0);
    send_check("j_type", 32'h001000EF, 3'b110, 32'h00000800, 1'b0, 64'h0000000000000800,
               32'h00000800, 1'b0);
  endtask

  task automatic test_u_type();
    send_check("u_pos", 32'h123450B7, 3'b010, 32'h12345000, 1'b0, 64'h0000000012345000,
               32'h12345000, 1'b0);
    send_check("u_neg", 32'h800000B7, 3'b010, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000,
               32'h80000000, 1'b0);
  endtask

  task automatic test_illegal();
    // R-type opcode: illegal for the auto build, ImmSrc=011 illegal for the explicit builds.
    send_check("ill_011", 32'hFFF00033, 3'b011, 32'h0, 1'b1, 64'h0, 32'h0, 1'b1);
    // Auto build ignores a bad ImmSrc when the opcode is a legal I-type.
    send_check("ill_111", 32'hFFF00093, 3'b111, 32'h0, 1'b1, 64'h0, 32'hFFFFFFFF, 1'b0);
    send_check("ill_100", 32'h00000013, 3'b100, 32'h0, 1'b1, 64'h0, 32'h00000000, 1'b0);
  endtask

  task automatic test_backpressure();
    OutReady = 1'b0; ImmSrc = 3'b000;
    Inst = 32'h00100093; InTag = 8'd1; InValid = 1'b1;
    @(posedge clk); #1;
    Inst = 32'h00200093; InTag = 8'd2;
    n_cmp++;
    if ({a_vld, a_tag, a_imm, a_in_rdy} !== {1'b1, 8'd1, 32'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL bp_first: got vld=%b tag=%0d imm=%h rdy=%b want 1/1/00000001/1",
               a_vld, a_tag, a_imm, a_in_rdy);
    end
    @(posedge clk); #1;
    Inst = 32'h00300093; InTag = 8'd3;
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if ({a_vld, a_tag, a_imm, a_in_rdy} !== {1'b1, 8'd1, 32'd1, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got vld=%b tag=%0d imm=%h rdy=%b want 1/1/00000001/0",
                 c, a_vld, a_tag, a_imm, a_in_rdy);
      end
      if (c == 0) begin
        @(posedge clk); #1;
      end
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({a_vld, a_tag, a_imm, a_in_rdy} !== {1'b1, 8'd2, 32'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL bp_drain2: got vld=%b tag=%0d imm=%h rdy=%b want 1/2/00000002/1",
               a_vld, a_tag, a_imm, a_in_rdy);
    end
    @(posedge clk); #1;
    InValid = 1'b0;
    n_cmp++;
    if ({a_vld, a_tag, a_imm} !== {1'b1, 8'd3, 32'd3}) begin
      n_bad++;
      $display("FAIL bp_drain3: got vld=%b tag=%0d imm=%h want 1/3/00000003", a_vld, a_tag, a_imm);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (a_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_empty: got vld=%b want 0", a_vld);
    end
  endtask

  task automatic test_back_to_back();
    OutReady = 1'b1; ImmSrc = 3'b000; InValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      InTag = 8'h40 + 8'(k); Inst = {12'(k + 5), 20'h00093};
      @(posedge clk); #1;
      n_cmp++;
      if ({a_vld, a_tag, a_imm, a_in_rdy} !== {1'b1, 8'h40 + 8'(k), 32'(k + 5), 1'b1}) begin
        n_bad++;
        $display("FAIL b2b%0d: got vld=%b tag=%h imm=%h rdy=%b want 1/%h/%h/1",
                 k, a_vld, a_tag, a_imm, a_in_rdy, 8'h40 + 8'(k), 32'(k + 5));
      end
    end
    InValid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    OutReady = 1'b0; ImmSrc = 3'b000; Inst = 32'hFFF00093; InValid = 1'b1;
    InTag = 8'h11;
    @(posedge clk); #1;
    InTag = 8'h22;
    @(posedge clk); #1;
    InValid = 1'b0;
    n_cmp++;
    if ({a_vld, a_tag, a_in_rdy} !== {1'b1, 8'h11, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_full: got vld=%b tag=%h rdy=%b want 1/11/0", a_vld, a_tag, a_in_rdy);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (a_in_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_rdy_low: got %b want 0", a_in_rdy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({a_vld, a_err, a_imm, a_tag, a_in_rdy} !== {41'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_cleared: got vld=%b err=%b imm=%h tag=%h rdy=%b want 0/0/0/0/1",
               a_vld, a_err, a_imm, a_tag, a_in_rdy);
    end
    OutReady = 1'b1; InTag = 8'h33; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    n_cmp++;
    if ({a_vld, a_tag} !== {1'b1, 8'h33}) begin
      n_bad++;
      $display("FAIL rst_fresh: got vld=%b tag=%h want 1/33", a_vld, a_tag);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (a_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_alone: got vld=%b want 0", a_vld);
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_u_type();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
